cnn_run_ctrl: RTL and testbench

Initiator for the CNN accelerator's `start`/`done`/`result` handshake, i.e. the on-chip equivalent of the simulation stimulus that drives `cnn_top`. It turns a host run request into a properly timed synchronous `start` pulse and waits for `done`, bounded by a watchdog. It then captures the 4-bit prediction, checks it against an expected label and keeps pass/fail statistics. It sits between board I/O (button, UART command decoder or LEDs) and `cnn_top`.

---
 rtl/cnn_run_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cnn_run_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn_run_ctrl.sv
// Run initiator for cnn_top: edge-triggered request -> timed start pulse -> wait for done under a watchdog.
// Captures the prediction, grades it against the expected label and keeps saturating pass/fail counts.
module cnn_run_ctrl #(
  parameter int START_PULSE_CYCLES = 100,
  parameter int TIMEOUT_CYCLES     = 1000000,
  parameter int CNT_W              = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [3:0]       expected,
  output logic             acc_start,
  input  logic             acc_done,
  input  logic [3:0]       acc_result,
  output logic             busy,
  output logic             result_valid,
  output logic [3:0]       result_q,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int PW = $clog2(START_PULSE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(START_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] WDOG_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_TIMEOUT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_req_d;
  logic             r_req_edge;
  logic             r_armed;
  logic [3:0]       r_expected;
  logic [PW-1:0]    r_pulse;
  logic [TW-1:0]    r_wdog;
  logic             r_acc_start;
  logic             r_busy;
  logic             r_result_valid;
  logic [3:0]       r_result_q;
  logic             r_pass;
  logic             r_timeout;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;

  logic w_req_edge;
  logic w_qdone;
  logic w_wdog_hit;
  logic w_pulse_end;
  logic w_busy_nxt;
  logic w_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A done only counts once a low level has been seen since this run started.
  always_comb begin
    w_state_nxt = r_state;
    w_req_edge  = req & ~r_req_d;
    w_qdone     = r_armed & acc_done;
    w_wdog_hit  = (r_wdog == WDOG_LAST);
    w_pulse_end = (r_pulse == PULSE_LAST);
    w_match     = (acc_result == r_expected) && (acc_result <= 4'd9);
    case (r_state)
      S_IDLE: begin
        if (r_req_edge) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_qdone)          w_state_nxt = S_CAPTURE;
        else if (w_wdog_hit)  w_state_nxt = S_TIMEOUT;
        else if (w_pulse_end) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_qdone)         w_state_nxt = S_CAPTURE;
        else if (w_wdog_hit) w_state_nxt = S_TIMEOUT;
      end
      S_CAPTURE: w_state_nxt = S_IDLE;
      S_TIMEOUT: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    // Busy also covers the cycle in which result_valid is presented.
    w_busy_nxt = (w_state_nxt != S_IDLE) || (r_state == S_CAPTURE) || (r_state == S_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_d        <= 1'b0;
      r_req_edge     <= 1'b0;
      r_armed        <= 1'b0;
      r_expected     <= 4'd0;
      r_pulse        <= '0;
      r_wdog         <= '0;
      r_acc_start    <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_q     <= 4'd0;
      r_pass         <= 1'b0;
      r_timeout      <= 1'b0;
      r_pass_cnt     <= '0;
      r_fail_cnt     <= '0;
    end else begin
      r_req_d        <= req;
      r_req_edge     <= w_req_edge & ~r_busy;
      r_acc_start    <= (w_state_nxt == S_START);
      r_busy         <= w_busy_nxt;
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_req_edge) begin
            r_expected <= expected;
            r_pulse    <= '0;
            r_wdog     <= '0;
            r_armed    <= 1'b0;
          end
        end
        S_START, S_WAIT: begin
          r_wdog <= r_wdog + TW'(1);
          if (r_state == S_START) r_pulse <= r_pulse + PW'(1);
          if (!acc_done) r_armed <= 1'b1;
        end
        S_CAPTURE: begin
          r_result_q     <= acc_result;
          r_pass         <= w_match;
          r_timeout      <= 1'b0;
          r_result_valid <= 1'b1;
          if (w_match) begin
            if (r_pass_cnt != {CNT_W{1'b1}}) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
          end else begin
            if (r_fail_cnt != {CNT_W{1'b1}}) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
          end
        end
        S_TIMEOUT: begin
          r_timeout      <= 1'b1;
          r_pass         <= 1'b0;
          r_result_valid <= 1'b1;
          if (r_fail_cnt != {CNT_W{1'b1}}) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign acc_start    = r_acc_start;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result_q     = r_result_q;
  assign pass         = r_pass;
  assign timeout      = r_timeout;
  assign pass_cnt     = r_pass_cnt;
  assign fail_cnt     = r_fail_cnt;

endmodule

// File: tb/tb_cnn_run_ctrl.sv
// Directed bench for cnn_run_ctrl: a scripted accelerator model drives done/result per run.
// Two instances share stimulus; the second uses 2-bit counters to exercise saturation.
module tb_cnn_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req, acc_done;
  logic [3:0] expected, acc_result;

  logic       a_acc_start, a_busy, a_result_valid, a_pass, a_timeout;
  logic [3:0] a_result_q;
  logic [15:0] a_pass_cnt, a_fail_cnt;
  logic       b_acc_start, b_busy, b_result_valid, b_pass, b_timeout;
  logic [3:0] b_result_q;
  logic [1:0] b_pass_cnt, b_fail_cnt;

  cnn_run_ctrl #(.START_PULSE_CYCLES(100), .TIMEOUT_CYCLES(500), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req(req), .expected(expected),
    .acc_start(a_acc_start), .acc_done(acc_done), .acc_result(acc_result),
    .busy(a_busy), .result_valid(a_result_valid), .result_q(a_result_q),
    .pass(a_pass), .timeout(a_timeout), .pass_cnt(a_pass_cnt), .fail_cnt(a_fail_cnt)
  );

  cnn_run_ctrl #(.START_PULSE_CYCLES(100), .TIMEOUT_CYCLES(500), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .req(req), .expected(expected),
    .acc_start(b_acc_start), .acc_done(acc_done), .acc_result(acc_result),
    .busy(b_busy), .result_valid(b_result_valid), .result_q(b_result_q),
    .pass(b_pass), .timeout(b_timeout), .pass_cnt(b_pass_cnt), .fail_cnt(b_fail_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int m_width, m_rv_at, m_rv_cnt, m_starts, m_busy_rv, m_busy_after, m_start_rv;

  // Cycle index c counts from the first cycle acc_start is seen high.
  task automatic run_one(input logic [3:0] lbl, input logic [3:0] res, input int done_at,
                         input int stale_drop, input int busy_pulse, input bit hold_req);
    logic prev;
    expected   = lbl;
    acc_result = res;
    acc_done   = (stale_drop >= 0);
    req        = 1'b0;
    step;
    req = 1'b1;
    step;
    step;
    chk("start_latency", a_acc_start, 1);
    m_width = 0; m_rv_at = -1; m_rv_cnt = 0; m_starts = 1;
    m_busy_rv = 0; m_busy_after = -1; m_start_rv = -1;
    prev = 1'b1;
    for (int c = 0; c < 700; c++) begin
      if (a_acc_start) m_width++;
      if (c > 0 && a_acc_start && !prev) m_starts++;
      prev = a_acc_start;
      if (a_result_valid) begin
        m_rv_cnt++;
        if (m_rv_at < 0) begin
          m_rv_at    = c;
          m_busy_rv  = a_busy;
          m_start_rv = a_acc_start;
        end
      end
      if (m_rv_at >= 0 && c == m_rv_at + 1) m_busy_after = a_busy;
      if (m_rv_at >= 0 && c == m_rv_at + 10) break;
      if (!hold_req && c == 2) req = 1'b0;
      if (busy_pulse >= 0) begin
        if (c == busy_pulse) req = 1'b1;
        else if (c == busy_pulse + 2) req = 1'b0;
      end
      if (m_rv_at >= 0)                         acc_done = 1'b0;
      else if (stale_drop >= 0 && c < stale_drop) acc_done = 1'b1;
      else                                      acc_done = (done_at >= 0 && c >= done_at);
      step;
    end
    req      = 1'b0;
    acc_done = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_acc_start"}, a_acc_start, 0);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_result_valid"}, a_result_valid, 0);
    chk({tag, "_result_q"}, a_result_q, 0);
    chk({tag, "_pass"}, a_pass, 0);
    chk({tag, "_timeout"}, a_timeout, 0);
    chk({tag, "_pass_cnt"}, a_pass_cnt, 0);
    chk({tag, "_fail_cnt"}, a_fail_cnt, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL sim_watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int rv_seen;
    rst = 1'b1; req = 1'b0; acc_done = 1'b0; expected = 4'd0; acc_result = 4'd0;
    repeat (10) step;
    chk_all_zero("reset");
    rst = 1'b0;
    step;

    // Normal run: done 200 cycles after the 100-cycle pulse ends.
    run_one(4'd1, 4'd1, 300, -1, -1, 1'b0);
    chk("norm_width", m_width, 100);
    chk("norm_rv_at", m_rv_at, 302);
    chk("norm_rv_cnt", m_rv_cnt, 1);
    chk("norm_busy_at_rv", m_busy_rv, 1);
    chk("norm_busy_after_rv", m_busy_after, 0);
    chk("norm_result_q", a_result_q, 1);
    chk("norm_pass", a_pass, 1);
    chk("norm_timeout", a_timeout, 0);
    chk("norm_pass_cnt", a_pass_cnt, 1);
    chk("norm_fail_cnt", a_fail_cnt, 0);

    // Mismatch, then out-of-range prediction, then out-of-range label equal to result.
    run_one(4'd1, 4'd7, 300, -1, -1, 1'b0);
    chk("mis7_result_q", a_result_q, 7);
    chk("mis7_pass", a_pass, 0);
    run_one(4'd1, 4'd12, 300, -1, -1, 1'b0);
    chk("oor12_result_q", a_result_q, 12);
    chk("oor12_pass", a_pass, 0);
    chk("oor12_fail_cnt", a_fail_cnt, 2);
    run_one(4'd12, 4'd12, 40, -1, -1, 1'b0);
    chk("oor_eq_pass", a_pass, 0);
    chk("oor_eq_fail_cnt", a_fail_cnt, 3);

    // Stale done from before the request drops at c=5, real done at c=60.
    run_one(4'd5, 4'd5, 60, 5, -1, 1'b0);
    chk("stale_rv_at", m_rv_at, 62);
    chk("stale_rv_cnt", m_rv_cnt, 1);
    chk("stale_pass", a_pass, 1);
    chk("stale_pass_cnt", a_pass_cnt, 2);

    // Early done 20 cycles into the start pulse.
    run_one(4'd4, 4'd4, 20, -1, -1, 1'b0);
    chk("early_width_le21", (m_width <= 21), 1);
    chk("early_rv_at", m_rv_at, 22);
    chk("early_result_q", a_result_q, 4);
    chk("early_pass_cnt", a_pass_cnt, 3);

    // Watchdog: done never arrives.
    run_one(4'd3, 4'd3, -1, -1, -1, 1'b0);
    chk("wdog_rv_at", m_rv_at, 501);
    chk("wdog_width", m_width, 100);
    chk("wdog_start_at_rv", m_start_rv, 0);
    chk("wdog_timeout", a_timeout, 1);
    chk("wdog_pass", a_pass, 0);
    chk("wdog_result_q_kept", a_result_q, 4);
    chk("wdog_fail_cnt", a_fail_cnt, 4);
    chk("wdog_rv_cnt", m_rv_cnt, 1);

    // New req edge while busy is dropped.
    run_one(4'd2, 4'd2, 300, -1, 50, 1'b0);
    chk("busyreq_starts", m_starts, 1);
    chk("busyreq_rv_cnt", m_rv_cnt, 1);
    chk("busyreq_timeout_clr", a_timeout, 0);
    chk("busyreq_pass_cnt", a_pass_cnt, 4);

    // req held high through and after the run.
    run_one(4'd6, 4'd6, 20, -1, -1, 1'b1);
    chk("hold_starts", m_starts, 1);
    chk("hold_rv_cnt", m_rv_cnt, 1);
    chk("hold_pass_cnt", a_pass_cnt, 5);
    chk("sat_pass_cnt_pre", b_pass_cnt, 3);

    // Reset at cycle 50 of START.
    expected = 4'd0; acc_result = 4'd0; req = 1'b0;
    step;
    req = 1'b1;
    step;
    step;
    chk("rstmid_start", a_acc_start, 1);
    repeat (50) step;
    rst = 1'b1;
    step;
    chk_all_zero("rstmid");
    chk("rstmid_sat_pass_cnt", b_pass_cnt, 0);
    rst = 1'b0;
    req = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (a_result_valid || a_acc_start) rv_seen++;
    end
    chk("rstmid_quiet", rv_seen, 0);

    // Five passes: 16-bit counter reads 5, 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) run_one(4'd3, 4'd3, 20, -1, -1, 1'b0);
    chk("five_pass_cnt", a_pass_cnt, 5);
    chk("five_sat_pass_cnt", b_pass_cnt, 3);
    chk("five_sat_fail_cnt", b_fail_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
